// File: rtl/seq_divider.sv
// Sequential signed 32-bit divider, one restoring step per cycle.
// Produces LO (quotient) and HI (remainder) with truncation toward zero.
module seq_divider (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] SIGN = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]  state;
  logic [4:0]  count;
  logic [31:0] dvd;
  logic [31:0] dvs;
  logic [31:0] rem;
  logic [31:0] quo;
  logic        neg_q;
  logic        neg_r;

  logic [32:0] trial;
  logic [32:0] diff;
  logic [31:0] rem_nx;
  logic        qbit;
  logic [31:0] a_mag;
  logic [31:0] b_mag;

  // Operand magnitudes; 0x80000000 maps onto itself as unsigned.
  always_comb begin
    a_mag = dividend[31] ? (~dividend + 32'd1) : dividend;
    b_mag = divisor[31]  ? (~divisor  + 32'd1) : divisor;
  end

  // One restoring step: shift in next dividend bit, subtract if no borrow.
  always_comb begin
    trial  = {rem, dvd[31]};
    diff   = trial - {1'b0, dvs};
    qbit   = ~diff[32];
    rem_nx = qbit ? diff[31:0] : trial[31:0];
  end

  // Control, datapath and result registers.
  always_ff @(posedge clock) begin
    if (clear) begin
      state       <= IDLE;
      count       <= 5'd0;
      dvd         <= 32'd0;
      dvs         <= 32'd0;
      rem         <= 32'd0;
      quo         <= 32'd0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      quotient    <= 32'd0;
      remainder   <= 32'd0;
      div_by_zero <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            dvd   <= a_mag;
            dvs   <= b_mag;
            rem   <= 32'd0;
            quo   <= 32'd0;
            neg_q <= dividend[31] ^ divisor[31];
            neg_r <= dividend[31];
            count <= 5'd0;
            if (divisor == 32'd0) begin
              quotient    <= 32'hFFFF_FFFF;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              state       <= DONE;
            end else begin
              div_by_zero <= 1'b0;
              state       <= CALC;
            end
          end
        end
        CALC: begin
          rem   <= rem_nx;
          quo   <= {quo[30:0], qbit};
          dvd   <= {dvd[30:0], 1'b0};
          count <= count + 5'd1;
          if (count == 5'd31)
            state <= SIGN;
        end
        SIGN: begin
          quotient  <= neg_q ? (~quo + 32'd1) : quo;
          remainder <= neg_r ? (~rem + 32'd1) : rem;
          state     <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Status flags decoded from state.
  always_comb begin
    busy = (state == CALC) || (state == SIGN);
    done = (state == DONE);
  end

endmodule

// File: tb/tb_seq_divider.sv
// Randomised self-checking bench for seq_divider.
// Results are compared against 64-bit signed arithmetic.
module tb_seq_divider;

  logic        clock;
  logic        clear;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  int total;
  int bad;

  seq_divider dut (
    .clock       (clock),
    .clear       (clear),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void model(input  logic [31:0] a,
                                input  logic [31:0] b,
                                output logic [31:0] q,
                                output logic [31:0] r,
                                output logic        z);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      z = 1'b1;
    end else begin
      q = 32'(sa / sb);
      r = 32'(sa % sb);
      z = 1'b0;
    end
  endfunction

  // Called #1 after an edge; start is sampled at the next edge (E0).
  task automatic run_div(input logic [31:0] a,
                         input logic [31:0] b,
                         input int          inj_at,
                         input string       tag);
    logic [31:0] eq;
    logic [31:0] er;
    logic        ez;
    int lat;
    int nbusy;
    int ndone;
    model(a, b, eq, er, ez);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clock);
    #1;
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    lat   = -1;
    nbusy = 0;
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      if (busy) nbusy++;
      if (done) begin
        ndone++;
        if (lat < 0) begin
          lat = c;
          chk({tag, ".q"}, quotient, eq);
          chk({tag, ".r"}, remainder, er);
          chk({tag, ".z"}, {31'd0, div_by_zero}, {31'd0, ez});
        end
      end
      start = (c == inj_at - 1);
      if (c == inj_at - 1) begin
        dividend = 32'd50;
        divisor  = 32'd5;
      end
      @(posedge clock);
      #1;
    end
    start = 1'b0;
    chk({tag, ".lat"}, 32'(lat), (b == 32'd0) ? 32'd0 : 32'd33);
    chk({tag, ".busy"}, 32'(nbusy), (b == 32'd0) ? 32'd0 : 32'd33);
    chk({tag, ".pulses"}, 32'(ndone), 32'd1);
    chk({tag, ".hold_q"}, quotient, eq);
    chk({tag, ".hold_r"}, remainder, er);
  endtask

  initial begin
    int ndone;
    logic [31:0] ra;
    logic [31:0] rb;
    total    = 0;
    bad      = 0;
    clear    = 1'b1;
    start    = 1'b1;
    dividend = 32'd100;
    divisor  = 32'd7;
    repeat (2) @(posedge clock);
    #1;
    start = 1'b0;
    chk("rst.q", quotient, 32'd0);
    chk("rst.r", remainder, 32'd0);
    chk("rst.flags", {29'd0, busy, done, div_by_zero}, 32'd0);
    clear = 1'b0;

    run_div(32'd100, 32'd7, -1, "p100_7");
    run_div(-32'sd100, 32'd7, -1, "n100_7");
    run_div(32'd100, -32'sd7, -1, "p100_n7");
    run_div(32'd5, 32'd0, -1, "div0");
    run_div(32'h8000_0000, 32'hFFFF_FFFF, -1, "ovf");
    run_div(32'd100, 32'd7, 5, "inject");

    // Abort a divide with clear at E10.
    dividend = 32'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clock);
    #1;
    clear = 1'b1;
    @(posedge clock);
    #1;
    clear = 1'b0;
    chk("abort.q", quotient, 32'd0);
    chk("abort.r", remainder, 32'd0);
    chk("abort.flags", {29'd0, busy, done, div_by_zero}, 32'd0);
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      if (done) ndone++;
      @(posedge clock);
      #1;
    end
    chk("abort.nodone", 32'(ndone), 32'd0);
    run_div(32'd9, 32'd3, -1, "p9_3");

    // Random operands with occasional corner values.
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: ra = 32'h8000_0000;
        3: rb = $urandom_range(1, 20);
        default: ;
      endcase
      run_div(ra, rb, -1, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; ports: clock (in, 1, rising-edge clock), clear (in, 1, synchronous active-high reset).
REQ-002 The block SHALL have port start (in, 1): request a divide; sampled only in IDLE.
REQ-003 The block SHALL have port dividend (in, 32): signed two's-complement numerator (Ra value); sampled with start.
REQ-004 The block SHALL have port divisor (in, 32): signed two's-complement denominator (Rb value); sampled with start.
REQ-005 The block SHALL have port quotient (out, 32): signed quotient, destined for LO.
REQ-006 The block SHALL have port remainder (out, 32): signed remainder, destined for HI.
REQ-007 The block SHALL have port busy (out, 1): high while a divide is in progress.
REQ-008 The block SHALL have port done (out, 1): one-cycle pulse; quotient/remainder valid.
REQ-009 The block SHALL have port div_by_zero (out, 1): set with done when the latched divisor was 0.

Function
REQ-010 The block SHALL implement FSM states IDLE, CALC, SIGN, DONE; all transitions on rising clock edge.
REQ-011 In IDLE with start=1 at edge E0, the block SHALL latch |dividend|, |divisor|, the dividend sign and the quotient sign (XOR of operand signs), clear a 5-bit step counter, and go to CALC; if divisor=0, it SHALL go to DONE instead.
REQ-012 CALC SHALL perform one unsigned restoring-division step per cycle (shift partial remainder left by 1, bring in next dividend bit MSB-first, subtract divisor if no borrow, shift quotient bit in), 32 steps at edges E1..E32, then go to SIGN.
REQ-013 Magnitudes SHALL be 32-bit unsigned; |0x80000000| = 0x80000000 with no overflow error.
REQ-014 At edge E33 SIGN SHALL register quotient = negated magnitude if the quotient sign is 1, and remainder = negated magnitude if the dividend sign is 1 (truncation toward zero), then go to DONE.
REQ-015 DONE SHALL assert done=1 for exactly one cycle (between E33 and E34 for a normal divide), then return to IDLE unconditionally.
REQ-016 busy SHALL be 1 in CALC and SIGN, and 0 in IDLE and DONE.
REQ-017 start SHALL be ignored in CALC, SIGN and DONE; latched operands SHALL not change mid-operation.
REQ-018 On divide-by-zero, DONE SHALL output quotient=0xFFFFFFFF, remainder=dividend, div_by_zero=1 (done high in the cycle after E0).
REQ-019 div_by_zero SHALL be cleared on the next accepted start with a nonzero divisor.
REQ-020 quotient and remainder SHALL hold their last completed values until the next completion or clear.
REQ-021 0x80000000 / 0xFFFFFFFF SHALL produce quotient=0x80000000, remainder=0 (wrap, no flag).
REQ-022 Total latency SHALL be 34 cycles from start edge to the done-high cycle end (done observed after E33); a back-to-back start is accepted in the first IDLE cycle after DONE.

Reset
REQ-023 With clear=1 at a rising edge, the block SHALL enter IDLE; quotient=0, remainder=0, busy=0, done=0, div_by_zero=0; counter and internal registers = 0.
REQ-024 clear SHALL take priority over start and over any in-progress operation; an aborted divide SHALL produce no done pulse.
REQ-025 Before the first clear the outputs are undefined; the bench SHALL apply clear for at least 1 cycle.

Verification
REQ-026 Bench: start with 100/7 -> busy high 33 cycles; done after E33; quotient=14 (0x0000000E), remainder=2, div_by_zero=0.
REQ-027 Bench: start with -100/7 -> quotient=0xFFFFFFF2 (-14), remainder=0xFFFFFFFE (-2); and 100/-7 -> quotient=-14, remainder=+2.
REQ-028 Bench: start with 5/0 -> done in the cycle after E0, busy never high, quotient=0xFFFFFFFF, remainder=5, div_by_zero=1.
REQ-029 Bench: start with 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0, div_by_zero=0.
REQ-030 Bench: clear asserted at E10 of a 100/7 divide -> next cycle busy=0, outputs 0, no done; a new 9/3 start then yields quotient=3, remainder=0.
REQ-031 Bench: start pulsed with 50/5 at E5 during a 100/7 divide -> ignored; result 14 rem 2; only one done pulse.
